// File: rtl/CPU_package.sv
// Shared instruction word layout for the fetch path and the control unit.
package CPU_package;
    localparam int DATA_WIDTH   = 16;
    localparam int OPCODE_WIDTH = 5;
    localparam int ADDR_WIDTH   = DATA_WIDTH - OPCODE_WIDTH;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [ADDR_WIDTH-1:0]   address;
    } instr_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers, occupancy count and sticky overflow for a power-of-two FIFO.
module fifo_ptr_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_in_valid,
    input  logic          i_out_ready,
    output logic [PW-1:0] o_wptr,
    output logic [PW-1:0] o_rptr,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_push,
    output logic          o_overflow
);
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_push  = i_in_valid & ~o_full & ~i_flush;
    assign w_pop   = i_out_ready & ~o_empty & ~i_flush;

    assign o_wptr     = r_wptr;
    assign o_rptr     = r_rptr;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

    // Flush dominates any push/pop in the same cycle; pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (o_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (o_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !o_push) begin
                r_count <= r_count - 1'b1;
            end
            if (i_in_valid && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/instruction_prefetch_queue.sv
// FIFO of fetched instruction words presenting the head already split into
// opcode/address fields, with flush for control-flow changes.
module instruction_prefetch_queue
    import CPU_package::instr_t;
#(
    parameter int DATA_WIDTH   = CPU_package::DATA_WIDTH,
    parameter int OPCODE_WIDTH = CPU_package::OPCODE_WIDTH,
    parameter int DEPTH        = 4
) (
    input  logic                             iclk,
    input  logic                             irst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            insin,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OPCODE_WIDTH-1:0]          opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] address,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] w_wptr;
    logic [PW-1:0] w_rptr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    instr_t        w_head;
    instr_t        r_mem [DEPTH];

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .i_clk       (iclk),
        .i_rst       (irst),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .o_wptr      (w_wptr),
        .o_rptr      (w_rptr),
        .o_count     (count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_push      (w_push),
        .o_overflow  (overflow)
    );

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;

    // Storage is deliberately left uncleared by reset/flush; only pointers matter.
    always_ff @(posedge iclk) begin
        if (w_push) begin
            r_mem[w_wptr] <= insin;
        end
    end

    assign w_head  = r_mem[w_rptr];
    assign opcode  = out_valid ? w_head.opcode  : '0;
    assign address = out_valid ? w_head.address : '0;
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Randomised scoreboard bench for instruction_prefetch_queue against a queue-based model.
module tb_instruction_prefetch_queue;
    localparam int DEPTH = 4;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] insin = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  opcode;
    logic [10:0] address;
    logic [2:0]  count;
    logic        overflow;

    int          checks = 0;
    int          failures = 0;
    int          modelCount = 0;
    bit          modelOv = 1'b0;
    logic [15:0] expQ[$];

    instruction_prefetch_queue #(.DATA_WIDTH(16), .OPCODE_WIDTH(5), .DEPTH(DEPTH)) dut (
        .iclk      (iclk),
        .irst      (irst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .insin     (insin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .address   (address),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 iclk = ~iclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called each falling edge: checks state left by the last rising edge, then
    // drives inputs for the next one and advances the model accordingly.
    task automatic applyStimulus(input bit v, input logic [15:0] w, input bit r, input bit f);
        bit pushNow;
        bit popNow;
        @(negedge iclk);
        checkOutput("count", int'(count), modelCount);
        checkOutput("out_valid", int'(out_valid), int'(modelCount > 0));
        checkOutput("in_ready", int'(in_ready), int'(modelCount < DEPTH));
        checkOutput("overflow", int'(overflow), int'(modelOv));
        if (modelCount == 0) begin
            checkOutput("emptyOpcode", int'(opcode), 0);
            checkOutput("emptyAddress", int'(address), 0);
        end else if (expQ.size() > 0) begin
            checkOutput("head", int'({opcode, address}), int'(expQ[0]));
        end
        in_valid  = v;
        insin     = w;
        out_ready = r;
        flush     = f;
        if (f) begin
            modelCount = 0;
            modelOv    = 1'b0;
            expQ.delete();
        end else begin
            pushNow = v && (modelCount < DEPTH);
            popNow  = r && (modelCount > 0);
            if (v && modelCount == DEPTH) modelOv = 1'b1;
            if (pushNow) expQ.push_back(w);
            modelCount = modelCount + int'(pushNow) - int'(popNow);
        end
    endtask

    task automatic asyncReset();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        #3 irst = 1'b1;
        #1;
        checkOutput("rstCount", int'(count), 0);
        checkOutput("rstOutValid", int'(out_valid), 0);
        checkOutput("rstInReady", int'(in_ready), 1);
        checkOutput("rstOpcode", int'(opcode), 0);
        checkOutput("rstAddress", int'(address), 0);
        irst = 1'b0;
        modelCount = 0;
        modelOv    = 1'b0;
        expQ.delete();
    endtask

    // Monitor: every accepted pop must hand over the oldest expected word.
    initial begin
        logic [15:0] expWord;
        forever begin
            @(negedge iclk);
            #2;
            if (out_valid && out_ready && !flush && !irst) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL popEmpty: got %0h expected no word at %0t", {opcode, address}, $time);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("popWord", int'({opcode, address}), int'(expWord));
                end
            end
        end
    end

    initial begin
        #12;
        checkOutput("resetCount", int'(count), 0);
        checkOutput("resetOutValid", int'(out_valid), 0);
        checkOutput("resetInReady", int'(in_ready), 1);
        checkOutput("resetOverflow", int'(overflow), 0);
        checkOutput("resetOpcode", int'(opcode), 0);
        irst = 1'b0;

        applyStimulus(1'b1, 16'h000B, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("firstOpcode", int'(opcode), 0);
        checkOutput("firstAddress", int'(address), 11);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

        applyStimulus(1'b1, 16'h4816, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hC064, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h000B, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 16'hA100 + 16'(i), 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
        repeat (DEPTH + 1) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'h3300 + 16'(i), 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 16'h5500 + 16'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h7777, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

        applyStimulus(1'b1, 16'h0A0A, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0B0B, 1'b0, 1'b0);
        asyncReset();
        applyStimulus(1'b1, 16'h9ABC, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            int phase;
            int pv;
            int pr;
            phase = (i / 100) % 3;
            pv = (phase == 0) ? 85 : (phase == 1) ? 50 : 20;
            pr = (phase == 0) ? 20 : (phase == 1) ? 50 : 85;
            applyStimulus($urandom_range(99, 0) < pv, 16'($urandom), $urandom_range(99, 0) < pr,
                          $urandom_range(99, 0) < 3);
            if (i == 700) asyncReset();
        end

        repeat (DEPTH + 2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        #4;
        checkOutput("drainedScoreboard", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_prefetch_queue.md
Name: instruction_prefetch_queue

Overview:
Parametrised successor to the single-entry instruction register. It buffers up to DEPTH fetched instruction words in FIFO order and presents the head entry already split into opcode and address fields, using a valid/ready handshake on both sides. It sits between instruction fetch (memory read data) and the control unit. It adds a flush for control-flow changes and a sticky overflow flag.

Parameters:
DATA_WIDTH, 16, instruction word width.
OPCODE_WIDTH, 5, opcode field width taken from the word MSBs; address field is DATA_WIDTH-OPCODE_WIDTH bits (11 by default).
DEPTH, 4, number of entries; must be a power of two and >= 2.

Ports:
iclk  input  1  clock, rising-edge active.
irst  input  1  reset, asynchronous, active-high.
flush  input  1  discard all queued entries (branch/jump taken).
in_valid  input  1  fetch presents a word on insin.
in_ready  output  1  queue can accept a word (= not full).
insin  input  DATA_WIDTH  fetched instruction word.
out_valid  output  1  head entry present (= not empty).
out_ready  input  1  control unit consumes the head this cycle.
opcode  output  OPCODE_WIDTH  head word bits [DATA_WIDTH-1 -: OPCODE_WIDTH].
address  output  DATA_WIDTH-OPCODE_WIDTH  head word low bits.
count  output  $clog2(DEPTH+1)  number of occupied entries.
overflow  output  1  sticky: a push was attempted while full.

Behaviour:
- Reset (irst=1, asynchronous): write/read pointers=0, count=0, overflow=0, out_valid=0, in_ready=1, opcode=0, address=0. Reset mid-stream discards all contents immediately, without waiting for a clock edge.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush. Both are evaluated on the rising edge of iclk.
- in_ready and out_valid are decoded from registered count only. There is no combinational path from out_ready to in_ready or from in_valid to out_valid.
- Latency: a word pushed at edge N is visible on opcode/address with out_valid=1 after edge N (one cycle). There is no fall-through in the same cycle.
- push only: write at wptr, wptr+1 (wraps modulo DEPTH), count+1.
- pop only: rptr+1 (wraps), count-1.
- push and pop together (requires 0<count<DEPTH): both pointers advance and count is unchanged.
- Full (count==DEPTH): in_ready=0. If in_valid=1 at an edge while full, the word is dropped, state is unchanged, and overflow is set to 1 (sticky).
- Empty (count==0): out_valid=0 and opcode/address are forced to 0; out_ready is ignored.
- flush=1 at an edge: pointers=0, count=0, overflow=0. A simultaneous push or pop is discarded, because flush dominates.
- opcode/address come from a combinational read of the storage at rptr, masked by out_valid. They are stable between edges.
- Storage contents are not cleared on reset or flush; only the pointers and count are.
- Arithmetic: pointers are $clog2(DEPTH) bits with natural wrap. count is one bit wider, so that DEPTH is representable.

Decomposition:
- CPU_package holds DATA_WIDTH, OPCODE_WIDTH and a derived ADDR_WIDTH constant.
- CPU_package also holds typedef instr_t as a packed struct {opcode, address} used for the storage array and head decode, so the control unit shares the same field split.
- One sub-module is natural: fifo_ptr_ctrl (pointers, count, full/empty, overflow), parameterised by DEPTH. Storage and field decode stay in the top.

Test Plan:
1. Reset, then push 16'h000B ({5'b00000,11'd11}) with out_ready=0 -> one cycle later: out_valid=1, opcode=5'b00000, address=11'd11, count=1.
2. Push 16'h4816 ({01001,22}), 16'hC064 ({11000,100}) and 16'h000B back-to-back, then pop one per cycle -> heads appear in order 01001/22, 11000/100, 00000/11; count goes 3,2,1,0; out_valid=0 and outputs are 0 after the last pop.
3. Fill to DEPTH=4, hold in_valid=1 with insin=16'hFFFF for 2 more cycles -> in_ready=0, count stays 4, overflow=1. Draining returns only the first 4 words; 16'hFFFF never appears.
4. With count=2, assert push and pop in the same cycle -> count stays 2, head advances, and the pushed word emerges after the older entry. Run this across the pointer wrap (wptr 3->0).
5. With count=3 and overflow=1, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, overflow=0, and the pushed word is lost.
6. Assert irst asynchronously mid-cycle with count=2 -> out_valid, count and opcode/address drop to 0 before the next iclk edge. After release, a new push is seen as the head.
